// File: rtl/rat_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rat_io_pkg
// Purpose  : Port map, status bit layout and shared types for the RAT
//            peripheral-side I/O responder.
// Revision : 1.0  initial release
// ============================================================================
package rat_io_pkg;

    // CPU port addresses
    localparam logic [7:0] c_PORT_SWITCHES = 8'h20;
    localparam logic [7:0] c_PORT_STATUS   = 8'h21;
    localparam logic [7:0] c_PORT_MASK_RW  = 8'h22;
    localparam logic [7:0] c_PORT_LEDS     = 8'h40;
    localparam logic [7:0] c_PORT_SSEG     = 8'h81;
    localparam logic [7:0] c_PORT_TC_LO    = 8'hB0;
    localparam logic [7:0] c_PORT_TC_HI    = 8'hB1;
    localparam logic [7:0] c_PORT_ACK      = 8'hB3;
    localparam logic [7:0] c_PORT_MASK_W   = 8'hB4;

    // Status vector layout: four sticky button events, then the timer tick
    localparam int c_STATUS_W = 5;
    localparam int c_BTN_LSB  = 0;
    localparam int c_BTN_EVTS = 4;
    localparam int c_TICK     = 4;

    typedef logic [c_STATUS_W-1:0] status_t;

endpackage : rat_io_pkg
`default_nettype wire

// File: rtl/rat_io_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : rat_io_edge_sync
// Purpose  : Per-bit two-flop synchronizer followed by a third flop used to
//            produce a one-cycle rising-edge pulse.
// Revision : 1.0  initial release
// ============================================================================
module rat_io_edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;

    // Metastability chain plus the delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule : rat_io_edge_sync
`default_nettype wire

// File: rtl/rat_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : rat_io_responder
// Purpose  : RAT CPU port-bus responder: output registers, interval timer,
//            synchronized button events and a level interrupt.
// Revision : 1.0  initial release
// ============================================================================
module rat_io_responder
    import rat_io_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int BTN_W    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    output logic [7:0]       IN_PORT,
    output logic             INT,
    input  logic [7:0]       SWITCHES,
    input  logic [BTN_W-1:0] BUTTONS,
    output logic [7:0]       LEDS,
    output logic [7:0]       SSEG_VAL
);

    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [7:0]       r_sw_s1;
    logic [7:0]       r_sw_s2;
    logic [7:0]       r_leds;
    logic [7:0]       r_sseg;
    logic [7:0]       r_tc_lo;
    logic [7:0]       r_tc_hi;
    logic [c_PW-1:0]  r_pre;
    logic [15:0]      r_cnt;
    status_t          r_status;
    status_t          r_mask;
    logic             r_int;

    logic [BTN_W-1:0] w_btn_rise;
    logic [3:0]       w_btn_evt;
    logic [15:0]      w_tc;
    logic             w_tc_wr;
    logic             w_pre_wrap;
    logic             w_tick_set;
    status_t          w_set;
    status_t          w_clr;

    rat_io_edge_sync #(
        .WIDTH (BTN_W)
    ) u_btn_sync (
        .clk     (CLK),
        .rst     (RESET),
        .i_async (BUTTONS),
        .o_rise  (w_btn_rise)
    );

    // Map button edges onto the four status event bits; missing buttons read 0
    for (genvar gi = 0; gi < c_BTN_EVTS; gi++) begin : g_btn_map
        if (gi < BTN_W) begin : g_present
            assign w_btn_evt[gi] = w_btn_rise[gi];
        end else begin : g_absent
            assign w_btn_evt[gi] = 1'b0;
        end
    end

    assign w_tc       = {r_tc_hi, r_tc_lo};
    assign w_tc_wr    = IO_STRB && ((PORT_ID == c_PORT_TC_LO) || (PORT_ID == c_PORT_TC_HI));
    assign w_pre_wrap = (r_pre == c_PW'(PRESCALE - 1));
    // A TC write restarts the count, so it never coincides with a tick
    assign w_tick_set = (w_tc != 16'd0) && !w_tc_wr && w_pre_wrap && (r_cnt == w_tc - 16'd1);

    assign w_set = {w_tick_set, w_btn_evt};
    assign w_clr = (IO_STRB && (PORT_ID == c_PORT_ACK)) ? OUT_PORT[c_STATUS_W-1:0] : '0;

    // Switch synchronizer (two stages only, no edge detect needed)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= SWITCHES;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // CPU-writable registers: LEDs, seven-segment, mask, terminal count
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_leds  <= '0;
            r_sseg  <= '0;
            r_mask  <= '0;
            r_tc_lo <= '0;
            r_tc_hi <= '0;
        end else if (IO_STRB) begin
            case (PORT_ID)
                c_PORT_LEDS:                  r_leds  <= OUT_PORT;
                c_PORT_SSEG:                  r_sseg  <= OUT_PORT;
                c_PORT_MASK_RW, c_PORT_MASK_W: r_mask  <= OUT_PORT[c_STATUS_W-1:0];
                c_PORT_TC_LO:                 r_tc_lo <= OUT_PORT;
                c_PORT_TC_HI:                 r_tc_hi <= OUT_PORT;
                default:                      ;
            endcase
        end
    end

    // Prescaler and interval counter; held at zero while TC is zero
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tc_wr || (w_tc == 16'd0)) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_pre_wrap) begin
            r_pre <= '0;
            r_cnt <= w_tick_set ? 16'd0 : r_cnt + 16'd1;
        end else begin
            r_pre <= r_pre + c_PW'(1);
        end
    end

    // Sticky status with write-1-to-clear; a same-edge set wins over the clear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_set;
        end
    end

    // Level interrupt, registered from the current status and mask
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_int <= 1'b0;
        end else begin
            r_int <= |(r_status & r_mask);
        end
    end

    // Read mux: combinational on PORT_ID, unmapped addresses read zero
    always_comb begin
        IN_PORT = 8'h00;
        case (PORT_ID)
            c_PORT_SWITCHES: IN_PORT = r_sw_s2;
            c_PORT_STATUS:   IN_PORT = {3'b000, r_status};
            c_PORT_MASK_RW:  IN_PORT = {3'b000, r_mask};
            default:         IN_PORT = 8'h00;
        endcase
    end

    assign LEDS     = r_leds;
    assign SSEG_VAL = r_sseg;
    assign INT      = r_int;

endmodule : rat_io_responder
`default_nettype wire

// File: tb/tb_rat_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rat_io_responder
// Purpose  : Directed, table-driven self-checking bench for rat_io_responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_rat_io_responder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_PORT;
    logic       INT;
    logic [7:0] SWITCHES;
    logic [3:0] BUTTONS;
    logic [7:0] LEDS;
    logic [7:0] SSEG_VAL;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] rd_sel = 8'h21;

    rat_io_responder #(
        .PRESCALE (1),
        .BTN_W    (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .IN_PORT  (IN_PORT),
        .INT      (INT),
        .SWITCHES (SWITCHES),
        .BUTTONS  (BUTTONS),
        .LEDS     (LEDS),
        .SSEG_VAL (SSEG_VAL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rd_addr;
        logic [7:0] exp_rd;
        logic [7:0] exp_leds;
        logic [7:0] exp_sseg;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, let one rising edge pass, then park on the read address
    task automatic cyc(input logic strb, input logic [7:0] addr, input logic [7:0] data);
        PORT_ID  = addr;
        OUT_PORT = data;
        IO_STRB  = strb;
        @(negedge CLK);
        IO_STRB  = 1'b0;
        PORT_ID  = rd_sel;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, rd_sel, 8'h00);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h40, 8'hA5, 8'h55, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 8'h81, 8'h3C, 8'h81, 8'h00, 8'hA5, 8'h3C};
        vecs[2] = '{1'b1, 8'h22, 8'h1F, 8'h22, 8'h1F, 8'hA5, 8'h3C};
        vecs[3] = '{1'b1, 8'hB4, 8'hE4, 8'h22, 8'h04, 8'hA5, 8'h3C};
        vecs[4] = '{1'b1, 8'h99, 8'h77, 8'h99, 8'h00, 8'hA5, 8'h3C};
        vecs[5] = '{1'b0, 8'h40, 8'h11, 8'h40, 8'h00, 8'hA5, 8'h3C};
        vecs[6] = '{1'b1, 8'h22, 8'h00, 8'h21, 8'h00, 8'hA5, 8'h3C};
        vecs[7] = '{1'b1, 8'h40, 8'h5A, 8'h20, 8'h00, 8'h5A, 8'h3C};

        RESET = 1'b1; PORT_ID = 8'h21; OUT_PORT = 8'h00; IO_STRB = 1'b0;
        SWITCHES = 8'h00; BUTTONS = 4'h0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;

        // Reset state
        chk("rst_leds",   LEDS,     8'h00);
        chk("rst_sseg",   SSEG_VAL, 8'h00);
        chk("rst_int",    {7'd0, INT}, 8'h00);
        chk("rst_status", IN_PORT,  8'h00);
        PORT_ID = 8'h22; #1;
        chk("rst_mask",   IN_PORT,  8'h00);

        // Register write/read table
        for (int i = 0; i < 8; i++) begin
            rd_sel = vecs[i].rd_addr;
            cyc(vecs[i].wr, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_rd", i),   IN_PORT,  vecs[i].exp_rd);
            chk($sformatf("vec%0d_leds", i), LEDS,     vecs[i].exp_leds);
            chk($sformatf("vec%0d_sseg", i), SSEG_VAL, vecs[i].exp_sseg);
        end

        // Switch synchronizer: two edges before the value appears
        rd_sel = 8'h20;
        SWITCHES = 8'h3C;
        idle(1);
        chk("sw_edge1", IN_PORT, 8'h00);
        idle(1);
        chk("sw_edge2", IN_PORT, 8'h3C);

        // Button 2 held: single event, INT one cycle later, ACK clears
        rd_sel = 8'h21;
        cyc(1'b1, 8'h22, 8'h04);
        BUTTONS = 4'b0100;
        idle(2);
        chk("btn_sync_lat", IN_PORT, 8'h00);
        idle(1);
        chk("btn_evt",      IN_PORT, 8'h04);
        chk("btn_int_lag",  {7'd0, INT}, 8'h00);
        idle(1);
        chk("btn_int",      {7'd0, INT}, 8'h01);
        idle(4);
        chk("btn_sticky",   IN_PORT, 8'h04);
        cyc(1'b1, 8'hB3, 8'h04);
        chk("btn_ack",      IN_PORT, 8'h00);
        idle(1);
        chk("btn_int_clr",  {7'd0, INT}, 8'h00);
        idle(5);
        chk("btn_held_once", IN_PORT, 8'h00);
        chk("btn_held_int",  {7'd0, INT}, 8'h00);
        BUTTONS = 4'b0000;
        idle(3);

        // Timer TC=5, PRESCALE=1: tick every 5 cycles
        cyc(1'b1, 8'h22, 8'h10);
        cyc(1'b1, 8'hB1, 8'h00);
        cyc(1'b1, 8'hB0, 8'h05);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            chk($sformatf("tmr_p1_c%0d", k), IN_PORT, (k == 5) ? 8'h10 : 8'h00);
        end
        cyc(1'b1, 8'hB3, 8'h10);
        chk("tmr_ack1",     IN_PORT, 8'h00);
        chk("tmr_int",      {7'd0, INT}, 8'h01);
        for (int k = 7; k <= 10; k++) begin
            idle(1);
            chk($sformatf("tmr_p2_c%0d", k), IN_PORT, (k == 10) ? 8'h10 : 8'h00);
        end
        cyc(1'b1, 8'hB3, 8'h10);
        chk("tmr_ack2",     IN_PORT, 8'h00);
        idle(3);
        chk("tmr_p3_pre",   IN_PORT, 8'h00);
        cyc(1'b1, 8'hB3, 8'h10);
        chk("tmr_ack_vs_set", IN_PORT, 8'h10);
        idle(1);
        chk("tmr_int_kept", {7'd0, INT}, 8'h01);
        cyc(1'b1, 8'hB3, 8'h10);
        cyc(1'b1, 8'hB0, 8'h00);
        for (int k = 0; k < 12; k++) begin
            idle(1);
            chk($sformatf("tmr_stop_%0d", k), IN_PORT, 8'h00);
        end

        // Button edge and ACK of the same bit on one clock
        cyc(1'b1, 8'h22, 8'h02);
        BUTTONS = 4'b0010;
        idle(4);
        chk("sim_evt",  IN_PORT, 8'h02);
        chk("sim_int0", {7'd0, INT}, 8'h01);
        BUTTONS = 4'b0000;
        idle(3);
        BUTTONS = 4'b0010;
        idle(2);
        cyc(1'b1, 8'hB3, 8'h02);
        chk("sim_set_wins", IN_PORT, 8'h02);
        chk("sim_int1", {7'd0, INT}, 8'h01);
        idle(1);
        chk("sim_int2", {7'd0, INT}, 8'h01);
        cyc(1'b1, 8'hB3, 8'h02);
        chk("sim_ack", IN_PORT, 8'h00);
        BUTTONS = 4'b0000;
        idle(3);

        // Reset mid-count with a simultaneous write
        cyc(1'b1, 8'h22, 8'h10);
        cyc(1'b1, 8'h40, 8'hFF);
        cyc(1'b1, 8'h81, 8'h5A);
        cyc(1'b1, 8'hB0, 8'h05);
        idle(8);
        chk("pre_rst_int",  {7'd0, INT}, 8'h01);
        chk("pre_rst_leds", LEDS, 8'hFF);
        RESET = 1'b1;
        cyc(1'b1, 8'h81, 8'h12);
        RESET = 1'b0;
        #1;
        chk("post_rst_leds",   LEDS,     8'h00);
        chk("post_rst_sseg",   SSEG_VAL, 8'h00);
        chk("post_rst_int",    {7'd0, INT}, 8'h00);
        chk("post_rst_status", IN_PORT,  8'h00);
        rd_sel = 8'h22;
        idle(1);
        chk("post_rst_mask",   IN_PORT,  8'h00);
        rd_sel = 8'h21;
        idle(8);
        chk("post_rst_timer",  IN_PORT,  8'h00);
        chk("post_rst_int2",   {7'd0, INT}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rat_io_responder
`default_nettype wire
